// File: rtl/fp16div_iter_if.sv
// Operand / result handshake bundle for the iterative fp16 divider.
// The slave side is the divider; the master side feeds operands and consumes results.
interface fp16div_iter_if;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_res;

    modport slave  (input  i_valid, i_a, i_b, i_ready,
                    output o_ready, o_valid, o_res);
    modport master (output i_valid, i_a, i_b, i_ready,
                    input  o_ready, o_valid, o_res);
endinterface

// File: rtl/fp16div_iter.sv
// Multi-cycle IEEE-754 binary16 divider (a / b) using radix-2 restoring division.
// Inputs are flushed to zero when denormal, results flush to zero on underflow,
// rounding is ties-to-even, and every generated NaN uses the NAN_MANT payload.
module fp16div_iter #(
    parameter logic [9:0] NAN_MANT = 10'h077
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    fp16div_iter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic [15:0]        a_q, b_q;
    logic               sgn;
    logic               spec_en;
    logic [15:0]        spec_res;
    logic [10:0]        mb;
    logic [11:0]        rem;
    logic [12:0]        q;
    logic [3:0]         cnt;
    logic signed [6:0]  expo;
    logic [15:0]        res;

    // Operand decode (DAZ: exponent 0 means signed zero).
    logic [4:0]  a_e, b_e;
    logic [9:0]  a_m, b_m;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sgn_w, k;
    logic [10:0] ma_w, mb_w;
    logic [11:0] rem_init;
    logic signed [6:0] exp_init;
    logic        sp_en_w;
    logic [15:0] sp_res_w;

    assign a_e    = a_q[14:10];
    assign b_e    = b_q[14:10];
    assign a_m    = a_q[9:0];
    assign b_m    = b_q[9:0];
    assign a_zero = (a_e == 5'd0);
    assign b_zero = (b_e == 5'd0);
    assign a_inf  = (a_e == 5'd31) && (a_m == 10'd0);
    assign b_inf  = (b_e == 5'd31) && (b_m == 10'd0);
    assign a_nan  = (a_e == 5'd31) && (a_m != 10'd0);
    assign b_nan  = (b_e == 5'd31) && (b_m != 10'd0);
    assign sgn_w  = a_q[15] ^ b_q[15];

    // Pre-normalise so the first quotient bit is always 1.
    assign ma_w     = {1'b1, a_m};
    assign mb_w     = {1'b1, b_m};
    assign k        = (ma_w < mb_w);
    assign rem_init = k ? {ma_w, 1'b0} : {1'b0, ma_w};
    assign exp_init = $signed({2'b00, a_e}) - $signed({2'b00, b_e}) + 7'sd15
                      - (k ? 7'sd1 : 7'sd0);

    // Special operands resolved in priority order: NaN, inf, zero.
    always_comb begin
        sp_en_w  = 1'b1;
        sp_res_w = {sgn_w, 15'd0};
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
            sp_res_w = {sgn_w, 5'h1f, NAN_MANT};
        else if (a_inf || b_zero)
            sp_res_w = {sgn_w, 5'h1f, 10'd0};
        else if (a_zero || b_inf)
            sp_res_w = {sgn_w, 15'd0};
        else
            sp_en_w = 1'b0;
    end

    // One restoring step: subtract when it fits, then shift.
    logic        ge;
    logic [11:0] rem_sub;
    assign ge      = (rem >= {1'b0, mb});
    assign rem_sub = ge ? (rem - {1'b0, mb}) : rem;

    // Rounding and range handling on the finished quotient.
    logic              up;
    logic [10:0]       mant_r;
    logic signed [6:0] exp_r;
    logic [15:0]       res_nxt;

    assign up     = q[1] & (q[0] | (rem != 12'd0) | q[2]);
    assign mant_r = {1'b0, q[11:2]} + {10'd0, up};
    assign exp_r  = expo + $signed({6'd0, mant_r[10]});

    always_comb begin
        res_nxt = {sgn, exp_r[4:0], mant_r[9:0]};
        if (spec_en)
            res_nxt = spec_res;
        else if (expo <= 7'sd0)
            res_nxt = {sgn, 15'd0};
        else if (exp_r >= 7'sd31)
            res_nxt = {sgn, 5'h1f, 10'd0};
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nxt = PREP;
            PREP:    state_nxt = DIV;
            DIV:     if (cnt == 4'd12) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (bus.i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands, set up division, iterate.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    a_q <= bus.i_a;
                    b_q <= bus.i_b;
                end
            end
            PREP: begin
                rem      <= rem_init;
                mb       <= mb_w;
                expo     <= exp_init;
                sgn      <= sgn_w;
                spec_en  <= sp_en_w;
                spec_res <= sp_res_w;
                q        <= 13'd0;
                cnt      <= 4'd0;
            end
            DIV: begin
                rem <= {rem_sub[10:0], 1'b0};
                q   <= {q[11:0], ge};
                cnt <= cnt + 4'd1;
            end
            default: ;
        endcase
    end

    // Result register, cleared on reset and loaded once per operation.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            res <= 16'h0000;
        else if (state == ROUND)
            res <= res_nxt;
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = (state == DONE);
    assign bus.o_res   = res;
endmodule

// File: tb/tb_fp16div_iter.sv
// Testbench for fp16div_iter: scoreboard of expected quotients from an exact
// integer reference, checked by an independent output monitor.
module tb_fp16div_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    fp16div_iter_if bus();

    fp16div_iter dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          acc;
    } item_t;

    item_t sb[$];
    logic        seen = 1'b0;
    logic [15:0] last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Exact quotient with round-to-nearest-even on 11 significant bits.
    function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
        logic   s, an, bn, ai, bi, az, bz;
        int     ae, be, ex, sh;
        longint ma, mb, n, qq, rr, frac, low, half;
        bit     up;
        s  = a[15] ^ b[15];
        ae = int'(a[14:10]);
        be = int'(b[14:10]);
        az = (ae == 0);
        bz = (be == 0);
        an = (ae == 31) && (a[9:0] != 0);
        bn = (be == 31) && (b[9:0] != 0);
        ai = (ae == 31) && (a[9:0] == 0);
        bi = (be == 31) && (b[9:0] == 0);
        if (an || bn || (ai && bi) || (az && bz)) return {s, 5'h1f, 10'h077};
        if (ai || bz) return {s, 5'h1f, 10'h000};
        if (az || bi) return {s, 15'h0000};
        ma = 1024 + longint'(a[9:0]);
        mb = 1024 + longint'(b[9:0]);
        n  = ma << 30;
        qq = n / mb;
        rr = n % mb;
        ex = ae - be + 15;
        if (qq >= (longint'(1) << 30)) sh = 20;
        else begin
            sh = 19;
            ex = ex - 1;
        end
        frac = qq >> sh;
        low  = qq & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        up   = (low > half) || ((low == half) && ((rr != 0) || ((frac % 2) == 1)));
        if (ex <= 0) return {s, 15'h0000};
        if (up) frac = frac + 1;
        if (frac == 2048) begin
            frac = 1024;
            ex   = ex + 1;
        end
        if (ex >= 31) return {s, 5'h1f, 10'h000};
        return {s, 5'(ex), 10'(frac)};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] sp [8];
        int r;
        sp[0] = 16'h0000; sp[1] = 16'h8000; sp[2] = 16'h7C00; sp[3] = 16'hFC00;
        sp[4] = 16'h7E00; sp[5] = 16'h0001; sp[6] = 16'h0400; sp[7] = 16'h7BFF;
        r = int'($urandom_range(0, 9));
        if (r == 0) return sp[$urandom_range(0, 7)];
        return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endfunction

    // Output monitor: new results are popped and compared; held results must stay stable.
    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (bus.o_valid) begin
            if (!seen) begin
                if (sb.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    item_t it;
                    it = sb.pop_front();
                    chk($sformatf("result %h/%h", it.a, it.b), {16'd0, bus.o_res}, {16'd0, it.exp});
                    chk("latency", 32'(cyc - it.acc), 32'd15);
                end
                seen = 1'b1;
                last = bus.o_res;
            end else begin
                chk("hold_stable", {16'd0, bus.o_res}, {16'd0, last});
            end
            if (bus.i_ready) seen = 1'b0;
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit inject);
        int t;
        item_t it;
        t = 0;
        while (!bus.o_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.o_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.i_valid = 1'b1;
        bus.i_a = a;
        bus.i_b = b;
        it.a = a;
        it.b = b;
        it.exp = ref_div(a, b);
        it.acc = cyc + 1;
        sb.push_back(it);
        @(posedge clk); #1;
        bus.i_valid = inject;
        bus.i_a = 16'($urandom);
        bus.i_b = 16'($urandom);
        t = 0;
        while (!bus.o_valid && t < 40) begin
            if (inject) chk("busy_not_ready", {31'd0, bus.o_ready}, 32'd0);
            @(posedge clk); #1;
            bus.i_a = 16'($urandom);
            bus.i_b = 16'($urandom);
            t++;
        end
        bus.i_valid = 1'b0;
        if (!bus.o_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_not_ready", {31'd0, bus.o_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk("consumed_valid_low", {31'd0, bus.o_valid}, 32'd0);
        chk("ready_after_consume", {31'd0, bus.o_ready}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] da [15];
        logic [15:0] db [15];
        da[0]  = 16'h4000; db[0]  = 16'h3C00;
        da[1]  = 16'hBC00; db[1]  = 16'h3C00;
        da[2]  = 16'h3C00; db[2]  = 16'h4200;
        da[3]  = 16'h3C00; db[3]  = 16'h3E00;
        da[4]  = 16'h3C00; db[4]  = 16'h3C00;
        da[5]  = 16'h3C00; db[5]  = 16'h0000;
        da[6]  = 16'h0000; db[6]  = 16'h0000;
        da[7]  = 16'h7C00; db[7]  = 16'hFC00;
        da[8]  = 16'h7E00; db[8]  = 16'h3C00;
        da[9]  = 16'h4000; db[9]  = 16'h7C00;
        da[10] = 16'h0001; db[10] = 16'h3C00;
        da[11] = 16'h7BFF; db[11] = 16'h3800;
        da[12] = 16'h0400; db[12] = 16'h4000;
        da[13] = 16'h7C00; db[13] = 16'h4000;
        da[14] = 16'h0000; db[14] = 16'hC000;

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a = 16'h0000;
        bus.i_b = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("reset_o_res", {16'd0, bus.o_res}, 32'd0);
        chk("reset_o_ready", {31'd0, bus.o_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(da[0], db[0], 10, 1'b1);
        for (int i = 1; i < 15; i++) run_op(da[i], db[i], 0, 1'b0);

        // Reset in the middle of the iteration discards the operation.
        bus.i_valid = 1'b1;
        bus.i_a = 16'h4000;
        bus.i_b = 16'h3C00;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("midreset_o_res", {16'd0, bus.o_res}, 32'd0);
        chk("midreset_o_ready", {31'd0, bus.o_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h4000, 16'h3C00, 0, 1'b0);

        for (int i = 0; i < 60; i++)
            run_op(rand_op(), rand_op(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        repeat (20) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
